// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared encodings for the memory-stage load engine
package load_pkg;

    // Load type encodings as presented on ld_type; 5..7 are illegal
    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LBU = 3'd1,
        LD_LH  = 3'd2,
        LD_LHU = 3'd3,
        LD_LW  = 3'd4
    } ld_type_e;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_TYPE    = 2'd3;

    // Load engine FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } ld_state_e;

    // True for the five defined load types
    function automatic logic type_legal(input logic [2:0] t);
        return (t <= 3'(LD_LW));
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault
    function automatic logic misaligned(input logic [2:0] t, input logic [1:0] lo);
        logic m;
        m = 1'b0;
        case (t)
            LD_LH, LD_LHU: m = lo[0];
            LD_LW:         m = (lo != 2'b00);
            default:       m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - little-endian byte/halfword select with sign or zero extension
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the load type
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        data = 32'd0;
        case (ld_type)
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'd0, byte_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'd0, half_sel};
            LD_LW:   data = word;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - single-outstanding load engine with req/ack memory read and write-back
module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_type,
    input  logic [4:0]  ld_rd,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        ld_err,
    output logic [1:0]  err_code
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    ld_state_e   state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [2:0]  type_q,  type_d;
    logic [4:0]  rd_q,    rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] data_q,  data_d;
    logic [1:0]  err_q,   err_d;
    logic [31:0] ext_data;

    // Extraction sits in the capture path so wb_data is a plain register
    load_extract u_extract (
        .word    (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .ld_type (type_q),
        .data    (ext_data)
    );

    // Next-state and capture logic; the ack beats the timeout in the last REQ cycle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_valid) begin
                    addr_d = ld_addr;
                    type_d = ld_type;
                    rd_d   = ld_rd;
                    cnt_d  = '0;
                    if (!type_legal(ld_type)) begin
                        err_d   = ERR_TYPE;
                        state_d = ST_ERR;
                    end else if (misaligned(ld_type, ld_addr[1:0])) begin
                        err_d   = ERR_ALIGN;
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    data_d  = ext_data;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = ERR_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                err_d   = ERR_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-request registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign ld_ready = (state_q == ST_IDLE);
    assign busy     = !ld_ready;
    assign mem_req  = (state_q == ST_REQ);
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign wb_valid = (state_q == ST_RESP);
    assign wb_data  = data_q;
    assign wb_rd    = rd_q;
    assign ld_err   = (state_q == ST_ERR);
    assign err_code = err_q;

endmodule
